// File: rtl/i2c_reg_pkg.sv
// Shared types and defaults for the I2C register bridge.
package i2c_reg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPtr,
        StWrite,
        StRead
    } state_e;

    localparam int unsigned DefNumRegs  = 16;
    localparam logic [7:0]  DefResetVal = 8'h00;

    // Pointer width for a register bank of n entries (never below one bit).
    function automatic int unsigned I2C_REG_AW(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_reg_bridge_if.sv
// Byte-level handshake between i2c_slave (master modport) and the register bridge (slave modport).
interface i2c_reg_bridge_if;
    logic [7:0] slv_data_out;
    logic       slv_data_vld;
    logic       slv_r_w;
    logic       slv_start;
    logic       slv_stop;
    logic [7:0] slv_data_in;
    logic       slv_ready;

    modport master (
        output slv_data_out, slv_data_vld, slv_r_w, slv_start, slv_stop,
        input  slv_data_in, slv_ready
    );

    modport slave (
        input  slv_data_out, slv_data_vld, slv_r_w, slv_start, slv_stop,
        output slv_data_in, slv_ready
    );
endinterface

// File: rtl/i2c_sync_pulse.sv
// 2-FF synchronizer followed by a registered rising-edge detector (3-cycle pin-to-pulse latency).
module i2c_sync_pulse (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 3'b000;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], async_in};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/i2c_reg_bridge.sv
// I2C slave to register-bank bridge with pointer/write/read phase decode and fabric write port.
// Define I2C_REG_AUTOINC_EN to auto-increment the pointer after every data byte.
module i2c_reg_bridge
    import i2c_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DefNumRegs,
    parameter logic [7:0]  RESET_VAL = DefResetVal,
    localparam int unsigned AW       = I2C_REG_AW(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_reg_bridge_if.slave       slv,
    input  logic                  hw_we,
    input  logic [AW-1:0]         hw_addr,
    input  logic [7:0]            hw_wdata,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  busy
);

    logic vld_p, start_p, stop_p;

    i2c_sync_pulse u_sync_vld (
        .clk      (clk),
        .rst      (rst),
        .async_in (slv.slv_data_vld),
        .pulse    (vld_p)
    );

    i2c_sync_pulse u_sync_start (
        .clk      (clk),
        .rst      (rst),
        .async_in (slv.slv_start),
        .pulse    (start_p)
    );

    i2c_sync_pulse u_sync_stop (
        .clk      (clk),
        .rst      (rst),
        .async_in (slv.slv_stop),
        .pulse    (stop_p)
    );

    // Data and direction are quasi-static around the strobe; two flops suffice.
    logic [7:0] data_s1_q, data_s2_q;
    logic       rw_s1_q, rw_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1_q <= 8'h00;
            data_s2_q <= 8'h00;
            rw_s1_q   <= 1'b0;
            rw_s2_q   <= 1'b0;
        end else begin
            data_s1_q <= slv.slv_data_out;
            data_s2_q <= data_s1_q;
            rw_s1_q   <= slv.slv_r_w;
            rw_s2_q   <= rw_s1_q;
        end
    end

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          i2c_we;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    data_in_q;
    logic          ready_q, ready_d;
    logic          busy_q;
    logic          reg_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        i2c_we  = 1'b0;

        unique case (state_q)
            StIdle: ;
            StPtr: begin
                if (vld_p) begin
                    if (!rw_s2_q) begin
                        ptr_d   = data_s2_q[AW-1:0];
                        state_d = StWrite;
                    end else begin
`ifdef I2C_REG_AUTOINC_EN
                        ptr_d   = ptr_q + 1'b1;
`endif
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                if (vld_p && !rw_s2_q) begin
                    i2c_we = 1'b1;
`ifdef I2C_REG_AUTOINC_EN
                    ptr_d  = ptr_q + 1'b1;
`endif
                end
            end
            StRead: begin
`ifdef I2C_REG_AUTOINC_EN
                if (vld_p) ptr_d = ptr_q + 1'b1;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (start_p) begin
            state_d = StPtr;
        end else if (stop_p) begin
            state_d = StIdle;
        end
    end

    // Any write landing on the currently pointed register invalidates the read byte.
    assign reg_hit = i2c_we || (hw_we && (hw_addr == ptr_q));
    assign ready_d = !((ptr_d != ptr_q) || reg_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            data_in_q <= 8'h00;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            data_in_q <= regs_q[ptr_q];
            ready_q   <= ready_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    // I2C write takes priority over a fabric write to the same register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= RESET_VAL;
            end else if (i2c_we && (ptr_q == AW'(i))) begin
                regs_q[i] <= data_s2_q;
            end else if (hw_we && (hw_addr == AW'(i))) begin
                regs_q[i] <= hw_wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign slv.slv_data_in = data_in_q;
    assign slv.slv_ready   = ready_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Scoreboard bench for i2c_reg_bridge (NUM_REGS=16); expectations follow I2C_REG_AUTOINC_EN.
module tb_i2c_reg_bridge;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hw_we = 1'b0;
    logic [3:0]   hw_addr = 4'h0;
    logic [7:0]   hw_wdata = 8'h00;
    logic [8*N-1:0] regs_flat;
    logic         busy;

    i2c_reg_bridge_if bus ();

    i2c_reg_bridge #(
        .NUM_REGS  (N),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slv       (bus.slave),
        .hw_we     (hw_we),
        .hw_addr   (hw_addr),
        .hw_wdata  (hw_wdata),
        .regs_flat (regs_flat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0=idle 1=ptr 2=write 3=read
    logic [7:0] m_regs [N];
    logic [3:0] m_ptr;
    int         m_state;
    logic [7:0] rd_q [$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_ptr   = 4'h0;
        m_state = 0;
    endtask

    task automatic model_inc();
`ifdef I2C_REG_AUTOINC_EN
        m_ptr = m_ptr + 4'h1;
`endif
    endtask

    task automatic send_start();
        @(negedge clk) bus.slv_start = 1'b1;
        repeat (4) @(negedge clk);
        bus.slv_start = 1'b0;
        repeat (3) @(negedge clk);
        m_state = 1;
    endtask

    task automatic send_stop();
        @(negedge clk) bus.slv_stop = 1'b1;
        repeat (4) @(negedge clk);
        bus.slv_stop = 1'b0;
        repeat (3) @(negedge clk);
        m_state = 0;
    endtask

    // Optional fabric write is aligned to the cycle in which vld_p is high.
    task automatic send_byte(input logic [7:0] b, input logic rw, input logic hw,
                             input logic [3:0] ha, input logic [7:0] hd);
        @(negedge clk);
        bus.slv_data_out = b;
        bus.slv_r_w      = rw;
        repeat (2) @(negedge clk);
        bus.slv_data_vld = 1'b1;
        repeat (3) @(negedge clk);
        if (hw) begin
            hw_we = 1'b1; hw_addr = ha; hw_wdata = hd;
        end
        @(negedge clk);
        hw_we = 1'b0;
        @(negedge clk);
        bus.slv_data_vld = 1'b0;
        repeat (4) @(negedge clk);
        if (hw) m_regs[ha] = hd;
        case (m_state)
            1: begin
                if (!rw) begin m_ptr = b[3:0]; m_state = 2; end
                else begin model_inc(); m_state = 3; end
            end
            2: if (!rw) begin m_regs[m_ptr] = b; model_inc(); end
            3: model_inc();
            default: ;
        endcase
    endtask

    task automatic hw_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        hw_we = 1'b1; hw_addr = a; hw_wdata = d;
        @(negedge clk);
        hw_we = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bus.slv_ready !== 1'b0 || bus.slv_data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b ready=%b data_in=%h, need 0 0 00",
                     busy, bus.slv_ready, bus.slv_data_in);
        end
        n_checks++;
        if (regs_flat !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: regs_flat=%h, need all 00", regs_flat);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.slv_ready !== 1'b1 || dut.ptr_q !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b ptr=%h, need 1 0", bus.slv_ready, dut.ptr_q);
        end
    endtask

    task automatic test_write();
        send_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL write_busy_open: busy=%b, need 1", busy);
        end
        send_byte(8'h03, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL write_busy_mid: busy=%b, need 1", busy);
        end
        send_stop();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL write_busy_closed: busy=%b, need 0", busy);
        end
        n_checks++;
        if (dut.ptr_q !== m_ptr) begin
            n_fail++; $display("FAIL write_ptr: ptr=%h, need %h", dut.ptr_q, m_ptr);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (regs_flat[8*i +: 8] !== m_regs[i]) begin
                n_fail++;
                $display("FAIL write_reg%0d: got %h, need %h", i, regs_flat[8*i +: 8], m_regs[i]);
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_b;
        int         waited;
        hw_write(4'h8, 8'h81);
        hw_write(4'h9, 8'h92);
        send_start();
        send_byte(8'h07, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'h3C, 1'b0, 1'b0, 4'h0, 8'h00);
        send_start();
        send_byte(8'h07, 1'b0, 1'b0, 4'h0, 8'h00);
        send_start();
        rd_q.push_back(m_regs[m_ptr]);
        send_byte(8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        rd_q.push_back(m_regs[m_ptr]);
        send_byte(8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        rd_q.push_back(m_regs[m_ptr]);
        send_stop();
        // Replay the read path from pointer 7 and drain expectations as bytes appear.
        send_start();
        send_byte(8'h07, 1'b0, 1'b0, 4'h0, 8'h00);
        send_start();
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            while (bus.slv_ready !== 1'b1 && waited < 20) begin
                @(negedge clk); waited++;
            end
            exp_b = rd_q.pop_front();
            n_checks++;
            if (bus.slv_ready !== 1'b1 || bus.slv_data_in !== exp_b) begin
                n_fail++;
                $display("FAIL read_byte%0d: ready=%b data_in=%h, need 1 %h",
                         k, bus.slv_ready, bus.slv_data_in, exp_b);
            end
            if (k < 2) send_byte(8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        end
        send_stop();
    endtask

    task automatic test_wrap();
        send_start();
        send_byte(8'h0F, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'h11, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'h22, 1'b0, 1'b0, 4'h0, 8'h00);
        send_start();
        send_byte(8'hF2, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'h33, 1'b0, 1'b0, 4'h0, 8'h00);
        send_stop();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (regs_flat[8*i +: 8] !== m_regs[i]) begin
                n_fail++;
                $display("FAIL wrap_reg%0d: got %h, need %h", i, regs_flat[8*i +: 8], m_regs[i]);
            end
        end
    endtask

    task automatic test_hw_collide();
        send_start();
        send_byte(8'h04, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'hC3, 1'b0, 1'b1, 4'h4, 8'h99);
        send_byte(8'h5E, 1'b0, 1'b1, 4'h9, 8'h77);
        send_stop();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (regs_flat[8*i +: 8] !== m_regs[i]) begin
                n_fail++;
                $display("FAIL hw_reg%0d: got %h, need %h", i, regs_flat[8*i +: 8], m_regs[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        send_start();
        send_byte(8'h0A, 1'b0, 1'b0, 4'h0, 8'h00);
        send_byte(8'hE1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++;
        if (regs_flat !== '0 || dut.ptr_q !== 4'h0 || bus.slv_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: regs_nonzero=%b ptr=%h ready=%b busy=%b, need 0 0 0 0",
                     |regs_flat, dut.ptr_q, bus.slv_ready, busy);
        end
        rst = 1'b0;
        send_byte(8'hE2, 1'b0, 1'b0, 4'h0, 8'h00);
        n_checks++;
        if (regs_flat !== '0 || dut.ptr_q !== m_ptr || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ignore: regs_nonzero=%b ptr=%h busy=%b, need 0 %h 0",
                     |regs_flat, dut.ptr_q, busy, m_ptr);
        end
    endtask

    initial begin
        bus.slv_data_out = 8'h00;
        bus.slv_data_vld = 1'b0;
        bus.slv_r_w      = 1'b0;
        bus.slv_start    = 1'b0;
        bus.slv_stop     = 1'b0;
        model_reset();
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_hw_collide();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bridge.md
# i2c_reg_bridge

Clocked register-file bridge sitting directly downstream of `i2c_slave`. It re-times the slave's byte strobes into the system clock domain, decodes pointer, write and read phases of each I2C transaction, and maintains an 8-bit register bank. On the return path it drives the slave's `data_in`/`ready` so that master reads stream out register contents with pointer auto-increment. A local fabric write port lets on-chip logic update registers between or during transactions.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 8-bit registers; must be a power of two, 2..256.
- `RESET_VAL`, 8'h00: reset value of every register.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high, sampled on `clk` rising edge.
- `slv_data_out`  in  8  byte received by `i2c_slave` (its `data_out`).
- `slv_data_vld`  in  1  byte-complete strobe from `i2c_slave` (asynchronous to `clk`).
- `slv_r_w`  in  1  transfer direction from `i2c_slave`; 1 = master read.
- `slv_start`  in  1  START / repeated-START indication (asynchronous).
- `slv_stop`  in  1  STOP indication (asynchronous).
- `slv_data_in`  out  8  byte offered to `i2c_slave` for master reads.
- `slv_ready`  out  1  `slv_data_in` is valid for the current pointer.
- `hw_we`  in  1  fabric write enable.
- `hw_addr`  in  $clog2(NUM_REGS)  fabric write address.
- `hw_wdata`  in  8  fabric write data.
- `regs_flat`  out  8*NUM_REGS  all registers; reg *i* at bits [8i+7:8i].
- `busy`  out  1  high while a transaction is open (state != IDLE).

## Operation
- `slv_data_vld`, `slv_start`, `slv_stop` each pass through a 2-FF synchronizer plus rising-edge detector, giving one-cycle pulses `vld_p`, `start_p`, `stop_p`. `slv_r_w` and `slv_data_out` pass through 2 FFs and are sampled together with `vld_p`.
- `ptr` width is $clog2(NUM_REGS). Pointer bytes use `slv_data_out[AW-1:0]`; upper bits are ignored. All increments wrap modulo NUM_REGS.
- FSM states:
  - IDLE: `start_p` -> PTR.
  - PTR: `vld_p` with r_w=0 -> `ptr` <= byte, go to WRITE. `vld_p` with r_w=1 -> `ptr`++, go to READ.
  - WRITE: `vld_p` with r_w=0 -> reg[`ptr`] <= byte, `ptr`++.
  - READ: `vld_p` -> `ptr`++.
- In every state, `stop_p` -> IDLE and `start_p` -> PTR. `ptr` is retained across STOP and repeated START.
- If `start_p` and `stop_p` occur in the same cycle, `start_p` wins (-> PTR).
- Fabric writes: `hw_we` writes `hw_wdata` to reg[`hw_addr`] in any state. If an I2C write targets the same register in the same cycle, the I2C write wins and the fabric write is dropped. A fabric write to a different register in that cycle completes normally.
- Reset values: state IDLE, `ptr` 0, all registers RESET_VAL, `slv_data_in` 0, `slv_ready` 0, `busy` 0, all synchronizer and edge flops 0.
- Reset asserted mid-transaction aborts it. The bridge stays in IDLE until the next `start_p` after reset is released.

## Timing
- Pin-to-pulse latency for `slv_*` strobes: 3 `clk` cycles (2 sync + 1 edge).
- Register and `ptr` updates take effect on the `clk` edge of the pulse cycle.
- `slv_data_in` <= reg[`ptr`] is registered every cycle. `slv_ready` is 0 in the cycle after any change to `ptr` or reg[`ptr`], otherwise 1 (out of reset).
- Stable `slv_data_in` with `slv_ready`=1 is therefore guaranteed 2 `clk` cycles after `vld_p`. The `clk` frequency must be at least 10× SCL.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `I2C_REG_AUTOINC_EN`:
  - Defined: `ptr` increments after every data byte in WRITE and READ, as described in Operation.
  - Undefined: `ptr` changes only on the pointer byte in PTR. Writes in WRITE all target the same register, and reads repeat the same register.

## Structure
- Shared package `i2c_reg_pkg`:
  - state enum (IDLE, PTR, WRITE, READ);
  - default `NUM_REGS` and `RESET_VAL`;
  - `I2C_REG_AW` helper function.
- Sub-module `i2c_sync_pulse`: 2-FF synchronizer plus rising-edge pulse, instantiated 3 times.

## Test plan
- Reset, then START, write 8'h03, 8'hA5, 8'h5A, STOP -> reg3=A5, reg4=5A, `ptr`=5, `busy` high between START and STOP.
- Set reg7=8'h3C via I2C, then repeated START with r_w=1 -> `slv_data_in`=3C with `slv_ready`=1; after `vld_p`, `slv_data_in`=reg8.
- With `ptr`=15 and NUM_REGS=16, write two bytes -> reg15 and reg0 are written (wrap); pointer byte 8'hF2 selects reg2.
- `hw_we` to reg4 in the same cycle as an I2C write to reg4 -> reg4 holds the I2C byte. `hw_we` to reg9 in the same cycle -> reg9 is updated.
- Assert `rst` between two data bytes -> all registers RESET_VAL, `ptr`=0, `slv_ready`=0. A later data byte without START is ignored.
- Build without `I2C_REG_AUTOINC_EN`, write 8'h02, 11, 22 -> reg2=22, reg3 unchanged.
